// File: rtl/scroll_engine_pkg.sv
// Purpose: shared OLED geometry constants and scroll FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scroll_engine_pkg;

    localparam int OLED_COLS       = 128;
    localparam int OLED_PAGES      = 8;
    localparam int SCROLL_WRAP_MAX = 1152;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } scroll_state_t;

endpackage

// File: rtl/scroll_engine_step_divider.sv
// Purpose: step-period divider that counts while running, holds otherwise, clears on demand.
// Latency: tick is combinational from the count; the count updates one clock later.
// Backpressure: none; clr overrides run.
module step_divider #(
    parameter int DIV_W = 24,
    parameter int DIV   = 400_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LP_LAST);
    assign tick   = run && w_last;

    // Count 0..DIV-1 while running, hold while stopped, clear wins over everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scroll_engine.sv
// Purpose: horizontal scroll-offset generator with run/pause/idle, direction, step size and seek.
// Latency: col_all/row_all combinational from disp_*; offset/wrapped/state registered (1 clk).
// Backpressure: none; the displayed offset only changes on a frame boundary.
module scroll_engine
    import scroll_engine_pkg::*;
#(
    parameter int COL_W    = 11,
    parameter int WRAP_MAX = SCROLL_WRAP_MAX,
    parameter int DIV_W    = 24,
    parameter int DIV      = 400_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       disp_col,
    input  logic [2:0]       disp_row,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             seek_valid,
    input  logic [COL_W-1:0] seek_offset,
    output logic [COL_W-1:0] col_all,
    output logic [2:0]       row_all,
    output logic [COL_W-1:0] offset,
    output logic             wrapped,
    output logic [1:0]       state
);

    // Arithmetic is one bit wider than the offset so sums above WRAP_MAX are never truncated.
    localparam logic [COL_W:0] LP_MAX      = (COL_W + 1)'(WRAP_MAX);
    localparam logic [COL_W:0] LP_M        = (COL_W + 1)'(WRAP_MAX + 1);
    localparam logic [6:0]     LP_LAST_COL = 7'(OLED_COLS - 1);
    localparam logic [2:0]     LP_LAST_ROW = 3'(OLED_PAGES - 1);

    scroll_state_t    r_state, w_state_nxt;
    logic [COL_W-1:0] r_offset, r_shown, w_step_off, w_seek_off;
    logic             r_wrapped, w_step_wrap, w_tick, w_frame_edge, w_run, w_clr;
    logic [6:0]       r_prev_col;
    logic [2:0]       r_prev_row;
    logic [COL_W:0]   w_s, w_ext, w_sum;

    // Divider runs only in RUN, freezes in PAUSE, restarts from 0 in IDLE or on seek.
    assign w_run = (r_state == ST_RUN);
    assign w_clr = (r_state == ST_IDLE) || seek_valid;

    step_divider #(
        .DIV_W (DIV_W),
        .DIV   (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: dropping en always returns to IDLE, even with a pause pulse present.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!en) w_state_nxt = ST_IDLE; else if (pause) w_state_nxt = ST_PAUSE;
            ST_PAUSE: if (!en) w_state_nxt = ST_IDLE; else if (pause) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_s   = (COL_W + 1)'(1) << speed;
    assign w_ext = {1'b0, r_offset};

    // Candidate next offset for a step, wrapping around the 0..WRAP_MAX ring.
    always_comb begin
        w_sum       = '0;
        w_step_wrap = 1'b0;
        w_step_off  = r_offset;
        if (!dir) begin
            w_sum = w_ext + w_s;
            if (w_sum > LP_MAX) begin
                w_step_wrap = 1'b1;
                w_sum       = w_sum - LP_M;
            end
        end else if (w_ext >= w_s) begin
            w_sum = w_ext - w_s;
        end else begin
            w_step_wrap = 1'b1;
            w_sum       = w_ext + LP_M - w_s;
        end
        w_step_off = w_sum[COL_W-1:0];
    end

    assign w_seek_off = ({1'b0, seek_offset} > LP_MAX) ? LP_MAX[COL_W-1:0] : seek_offset;

    // Working offset: seek beats a coincident step, which is then dropped with no wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset  <= '0;
            r_wrapped <= 1'b0;
        end else if (seek_valid) begin
            r_offset  <= w_seek_off;
            r_wrapped <= 1'b0;
        end else if (w_tick) begin
            r_offset  <= w_step_off;
            r_wrapped <= w_step_wrap;
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign w_frame_edge = (r_prev_row == LP_LAST_ROW && r_prev_col == LP_LAST_COL) &&
                          !(disp_row == LP_LAST_ROW && disp_col == LP_LAST_COL);

    // Latch the working offset into the shown offset once per frame so no frame is torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_col <= '0;
            r_prev_row <= '0;
            r_shown    <= '0;
        end else begin
            r_prev_col <= disp_col;
            r_prev_row <= disp_row;
            if (w_frame_edge) r_shown <= r_offset;
        end
    end

    assign col_all = COL_W'(disp_col) + r_shown;
    assign row_all = disp_row;
    assign offset  = r_offset;
    assign wrapped = r_wrapped;
    assign state   = r_state;

endmodule

// File: tb/tb_scroll_engine.sv
module tb_scroll_engine;

    localparam int DIV  = 4;
    localparam int WMAX = 1152;
    localparam int M    = WMAX + 1;

    logic        clk, rst, en, dir, pause, seek_valid;
    logic [1:0]  speed;
    logic [6:0]  disp_col;
    logic [2:0]  disp_row;
    logic [10:0] seek_offset, col_all, offset;
    logic [2:0]  row_all;
    logic        wrapped;
    logic [1:0]  state;

    int n_chk  = 0;
    int n_fail = 0;

    scroll_engine #(.COL_W(11), .WRAP_MAX(WMAX), .DIV_W(24), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .disp_col(disp_col), .disp_row(disp_row),
        .en(en), .dir(dir), .speed(speed), .pause(pause),
        .seek_valid(seek_valid), .seek_offset(seek_offset),
        .col_all(col_all), .row_all(row_all), .offset(offset),
        .wrapped(wrapped), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state 0 idle / 1 run / 2 pause; m_cnt = run cycles since last divider clear.
    int m_state = 0, m_off = 0, m_shown = 0, m_cnt = 0, m_wr = 0, m_pc = 0, m_pr = 0;
    int m_s, m_nxt;
    bit m_frame, m_step, m_wrap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_off = 0; m_shown = 0; m_cnt = 0; m_wr = 0; m_pc = 0; m_pr = 0;
        end else begin
            m_frame = (m_pr == 7 && m_pc == 127) && !(disp_row == 7 && disp_col == 127);
            if (m_frame) m_shown = m_off;
            m_s    = 1 << speed;
            m_step = (m_state == 1) && (m_cnt % DIV == DIV - 1);
            if (dir == 1'b0) begin
                m_wrap = (m_off + m_s > WMAX);
                m_nxt  = (m_off + m_s) % M;
            end else begin
                m_wrap = (m_off < m_s);
                m_nxt  = (m_off - m_s + M) % M;
            end
            if (seek_valid) begin
                m_off = (seek_offset > WMAX) ? WMAX : int'(seek_offset);
                m_wr  = 0;
            end else if (m_step) begin
                m_off = m_nxt;
                m_wr  = m_wrap ? 1 : 0;
            end else begin
                m_wr = 0;
            end
            if (m_state == 0 || seek_valid) m_cnt = 0;
            else if (m_state == 1) m_cnt++;
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!en) m_state = 0; else if (pause) m_state = 2;
                default: if (!en) m_state = 0; else if (pause) m_state = 1;
            endcase
            m_pc = disp_col;
            m_pr = disp_row;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("state",     int'(state),   m_state);
        chk("offset",    int'(offset),  m_off);
        chk("wrapped",   int'(wrapped), m_wr);
        chk("col_all",   int'(col_all), (int'(disp_col) + m_shown) % 2048);
        chk("row_all",   int'(row_all), int'(disp_row));
        chk("off_range", int'(offset <= 11'(WMAX)), 1);
    endtask

    // One clock: compare on the falling edge, then advance the pixel sweep after the rising edge.
    task automatic tick_cyc();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
        if (disp_col == 7'd127) begin
            disp_col = 7'd0;
            disp_row = disp_row + 3'd1;
        end else begin
            disp_col = disp_col + 7'd1;
        end
        #1;
    endtask

    task automatic wait_px(input int r, input int c);
        bit found;
        found = 0;
        for (int i = 0; i < 2100; i++) begin
            if (int'(disp_row) == r && int'(disp_col) == c) begin
                found = 1;
                break;
            end
            tick_cyc();
        end
        if (!found) chk("wait_px_timeout", 0, 1);
    endtask

    task automatic wait_wrap(input string nm, input int exp_off);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cyc();
            if (wrapped) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_offset"}, int'(offset), exp_off);
            tick_cyc();
            chk({nm, "_pulse_len"}, int'(wrapped), 0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 0; dir = 0; speed = 0; pause = 0; seek_valid = 0; seek_offset = '0;
        disp_col = '0; disp_row = '0;
        repeat (3) tick_cyc();
        chk("rst_offset",  int'(offset),  0);
        chk("rst_state",   int'(state),   0);
        chk("rst_wrapped", int'(wrapped), 0);
        chk("rst_col_all", int'(col_all), int'(disp_col));
        rst = 1'b0;

        // Forward scrolling from reset: one step every DIV cycles after RUN is entered.
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick_cyc();
            chk("seq_offset", int'(offset), (k - 1) / 4);
        end
        chk("seq_state", int'(state), 1);

        // Shown offset stays at 0 for the whole first frame.
        wait_px(1, 5);
        chk("frame0_col_all", int'(col_all), 5);
        chk("frame0_moving",  int'(offset != 0), 1);
        wait_px(0, 0);
        chk("edge_cycle_col_all", int'(col_all), 0);
        wait_px(0, 5);
        chk("frame1_col_all_moved", int'(col_all != 11'd5), 1);

        // Forward wrap with s=4.
        speed = 2'd2; seek_valid = 1; seek_offset = 11'd1150;
        tick_cyc();
        seek_valid = 0;
        chk("fwd_seek", int'(offset), 1150);
        wait_wrap("fwd_wrap", 1);

        // Backward wrap with s=8.
        dir = 1; speed = 2'd3; seek_valid = 1; seek_offset = 11'd2;
        tick_cyc();
        seek_valid = 0;
        chk("bwd_seek", int'(offset), 2);
        wait_wrap("bwd_wrap", 1147);

        // Pause mid-count, hold 20 cycles, resume with the held divider count.
        dir = 0; speed = 0; seek_valid = 1; seek_offset = 11'd100;
        tick_cyc();
        seek_valid = 0;
        tick_cyc();
        pause = 1;
        tick_cyc();
        pause = 0;
        chk("pause_state", int'(state), 2);
        for (int i = 0; i < 20; i++) begin
            tick_cyc();
            chk("pause_frozen", int'(offset), 100);
            chk("pause_hold_state", int'(state), 2);
        end
        pause = 1;
        tick_cyc();
        pause = 0;
        chk("resume_state", int'(state), 1);
        chk("resume_offset0", int'(offset), 100);
        tick_cyc();
        chk("resume_offset1", int'(offset), 100);
        tick_cyc();
        chk("resume_offset2", int'(offset), 101);

        // Clamp an out-of-range seek.
        seek_valid = 1; seek_offset = 11'd2000;
        tick_cyc();
        seek_valid = 0;
        chk("clamp", int'(offset), 1152);

        // Seek coinciding with a step that would otherwise wrap from 1152 to 0.
        for (int i = 0; i < 10; i++) begin
            if (m_state == 1 && (m_cnt % DIV) == DIV - 1) break;
            tick_cyc();
        end
        chk("prio_tick_found", int'(m_state == 1 && (m_cnt % DIV) == DIV - 1), 1);
        seek_valid = 1; seek_offset = 11'd1152;
        tick_cyc();
        seek_valid = 0;
        chk("prio_offset",  int'(offset),  1152);
        chk("prio_wrapped", int'(wrapped), 0);

        // en=0 beats pause.
        en = 0; pause = 1;
        tick_cyc();
        pause = 0;
        chk("en_prio_state", int'(state), 0);
        en = 1;
        tick_cyc();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 99) != 0);
            pause       = ($urandom_range(0, 39) == 0);
            seek_valid  = ($urandom_range(0, 59) == 0);
            seek_offset = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 49) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            tick_cyc();
        end
        pause = 0; seek_valid = 0;

        // Asynchronous reset in the middle of a cycle while running.
        en = 0;
        tick_cyc();
        en = 1;
        tick_cyc();
        seek_valid = 1; seek_offset = 11'd500;
        tick_cyc();
        seek_valid = 0;
        tick_cyc();
        chk("pre_rst_state", int'(state), 1);
        #2;
        rst = 1'b1;
        #2;
        chk("arst_offset",  int'(offset),  0);
        chk("arst_state",   int'(state),   0);
        chk("arst_wrapped", int'(wrapped), 0);
        chk("arst_col_all", int'(col_all), int'(disp_col));
        tick_cyc();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
